// File: rtl/button_reader_pkg.sv
// Shared types and defaults for the button reader.
// Holds the per-button FSM encoding and the default timing constants.
package button_reader_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic [31:0] DEBOUNCE_CYCLES_DEF = 32'd1000000;
    localparam logic [31:0] LONG_CYCLES_DEF     = 32'd50000000;
    localparam logic [31:0] CNT_MAX             = 32'hFFFF_FFFF;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, debounce FSM, long-press timer
// and registered level/press/release/long outputs.
module btn_debounce_cell
    import button_reader_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [31:0] LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    logic [1:0]  sync_q;
    logic        synced;
    btn_state_e  state_q;
    logic [31:0] deb_q;
    logic [31:0] hold_q;
    logic        level_q;
    logic        press_q;
    logic        release_q;
    logic        long_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign synced = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (synced) begin
                        state_q <= PRESS_WAIT;
                        deb_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!synced) begin
                        state_q <= IDLE;
                    end else if (deb_q == DEBOUNCE_CYCLES - 32'd1) begin
                        state_q <= PRESSED;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        deb_q <= deb_q + 32'd1;
                    end
                end
                PRESSED: begin
                    if (!synced) begin
                        state_q <= RELEASE_WAIT;
                        deb_q   <= '0;
                    end else if (hold_q != CNT_MAX) begin
                        // equality fires once, so one long pulse per press
                        hold_q <= hold_q + 32'd1;
                        long_q <= (hold_q == LONG_CYCLES - 32'd1);
                    end
                end
                RELEASE_WAIT: begin
                    if (synced) begin
                        state_q <= PRESSED;
                    end else if (deb_q == DEBOUNCE_CYCLES - 32'd1) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        deb_q <= deb_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/button_reader.sv
// Debounced multi-button reader with press/release/long-press events
// and a wrapping 8-bit count of accepted presses.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int          N_BTN           = 4,
    parameter logic [31:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [31:0] LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [7:0]       press_count
);

    logic [7:0] press_inc;
    logic [7:0] count_q;
    logic [7:0] count_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn_in[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g]),
            .long_o   (btn_long[g])
        );
    end

    always_comb begin
        press_inc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_inc = press_inc + {7'd0, btn_press[i]};
        end
        count_d = count_q + press_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign press_count = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: run-length reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_button_reader;

    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;
    logic [7:0]   press_count;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    button_reader #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(32'd4),
        .LONG_CYCLES    (32'd16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] p1, p2, prev_s;
    logic [N-1:0] m_level, m_press, m_rel, m_long;
    logic [7:0]   m_cnt;
    int           run_len[N];
    int           hold[N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        p1 = '0; p2 = '0; prev_s = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
        m_cnt = '0;
        for (int i = 0; i < N; i++) begin
            run_len[i] = 0;
            hold[i] = 0;
        end
    endtask

    // A level change is accepted once the synchronized input has shown
    // the new value for D+1 consecutive edges.
    task automatic model_step();
        logic [N-1:0] s;
        s = p2;
        p2 = p1;
        p1 = btn_in;
        for (int i = 0; i < N; i++) m_cnt = m_cnt + 8'(m_press[i]);
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_level[i]) run_len[i]++;
            else run_len[i] = 0;
            if (run_len[i] == D + 1) begin
                m_level[i] = s[i];
                run_len[i] = 0;
                if (s[i]) begin
                    m_press[i] = 1'b1;
                    hold[i] = 0;
                end else begin
                    m_rel[i] = 1'b1;
                end
            end else if (m_level[i] && s[i] && prev_s[i] && hold[i] < L) begin
                hold[i]++;
                if (hold[i] == L) m_long[i] = 1'b1;
            end
            prev_s[i] = s[i];
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cyc_level", 32'(btn_level), 32'(m_level));
                chk("cyc_press", 32'(btn_press), 32'(m_press));
                chk("cyc_release", 32'(btn_release), 32'(m_rel));
                chk("cyc_long", 32'(btn_long), 32'(m_long));
                chk("cyc_count", 32'(press_count), 32'(m_cnt));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        // single clean press on button 0
        tick(1);
        btn_in = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t027_press", 32'(btn_press[0]), 32'(c == 7));
            if (c == 7) chk("t027_level", 32'(btn_level[0]), 32'd1);
            if (c == 8) chk("t027_count", 32'(press_count), 32'd1);
        end

        // bounce on button 1 never accepted
        tick(1);
        btn_in[1] = 1'b1; tick(1);
        btn_in[1] = 1'b0; tick(1);
        btn_in[1] = 1'b1; tick(1);
        btn_in[1] = 1'b0;
        tick(12);
        chk("t028_level", 32'(btn_level[1]), 32'd0);
        chk("t028_count", 32'(press_count), 32'd1);

        // long hold on button 2
        btn_in[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            if (c == 30) begin
                #1;
                btn_in[2] = 1'b0;
            end
            @(negedge clk);
            chk("t029_press", 32'(btn_press[2]), 32'(c == 7));
            chk("t029_long", 32'(btn_long[2]), 32'(c == 23));
            chk("t029_release", 32'(btn_release[2]), 32'(c == 37));
        end

        // simultaneous press of all buttons
        tick(1);
        btn_in = '0;
        tick(12);
        btn_in = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t030_press", 32'(btn_press), (c == 7) ? 32'hF : 32'h0);
            if (c == 8) chk("t030_count", 32'(press_count), 32'd6);
        end

        // run the counter up to the wrap point
        tick(1);
        btn_in = '0;
        tick(12);
        for (int r = 0; r < 62; r++) begin
            btn_in = 4'hF; tick(10);
            btn_in = 4'h0; tick(10);
        end
        chk("t031_254", 32'(press_count), 32'd254);
        btn_in = 4'h1; tick(10);
        chk("t031_255", 32'(press_count), 32'd255);
        btn_in = 4'h0; tick(10);
        btn_in = 4'h1; tick(10);
        chk("t031_wrap", 32'(press_count), 32'd0);
        btn_in = 4'h0; tick(10);
        btn_in = 4'h1; tick(10);
        chk("t031_one", 32'(press_count), 32'd1);
        btn_in = 4'h0; tick(12);

        // reset in the middle of a debounce
        btn_in = 4'h1;
        tick(4);
        rst = 1'b1;
        #1;
        chk("t032_rst_count", 32'(press_count), 32'd0);
        chk("t032_rst_out",
            32'({btn_level, btn_press, btn_release, btn_long}), 32'd0);
        tick(2);
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t032_press", 32'(btn_press[0]), 32'(c == 7));
        end
        chk("t032_count", 32'(press_count), 32'd1);

        tick(1);
        btn_in = '0;
        tick(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
